// File: rtl/bcd_mem_sequencer_if.sv
// Write-side bus of bcd_mem_sequencer: request, snapshot fields, ready handshake
// and the registered write port toward the RTC register memory.
interface bcd_mem_sequencer_if #(
    parameter int NUM_FIELDS = 6,
    parameter int FIELD_W    = 8,
    parameter int ADDR_W     = 4
);
    logic                          start_i;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_i;
    logic                          mem_ready_i;
    logic [ADDR_W-1:0]             addr_o;
    logic [FIELD_W-1:0]            data_o;
    logic                          write_en_o;
    logic                          busy_o;
    logic                          done_o;

    modport master (
        output start_i, fields_i, mem_ready_i,
        input  addr_o, data_o, write_en_o, busy_o, done_o
    );

    modport slave (
        input  start_i, fields_i, mem_ready_i,
        output addr_o, data_o, write_en_o, busy_o, done_o
    );
endinterface

// File: rtl/bcd_mem_sequencer.sv
// Copies a one-cycle snapshot of NUM_FIELDS BCD fields to BASE_ADDR.. under a ready handshake.
// Optional macro CHANGED_ONLY_EN: suppress writes of fields equal to the last value written.
module bcd_mem_sequencer #(
    parameter int NUM_FIELDS = 6,
    parameter int FIELD_W    = 8,
    parameter int ADDR_W     = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_mem_sequencer_if.slave    bus
);
    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FIELDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    if (BASE_ADDR + NUM_FIELDS - 1 >= (1 << ADDR_W)) begin : g_addr_check
        $error("bcd_mem_sequencer: BASE_ADDR+NUM_FIELDS-1 does not fit in ADDR_W bits");
    end

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d, idx_nxt;
    logic                            pending_q, pending_d;
    logic [NUM_FIELDS*FIELD_W-1:0]   snap_q, snap_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [FIELD_W-1:0]              data_q, data_d;
    logic                            we_q, we_d;
    logic                            done_q, done_d;
    logic                            advance, accept;
    logic                            need_first, need_next;

    logic [FIELD_W-1:0] in_f   [NUM_FIELDS];
    logic [FIELD_W-1:0] snap_f [NUM_FIELDS];

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fields
        assign in_f[g]   = bus.fields_i[g*FIELD_W +: FIELD_W];
        assign snap_f[g] = snap_q[g*FIELD_W +: FIELD_W];
    end

    assign idx_nxt = idx_q + IDX_W'(1);
    assign accept  = (state_q == WRITE) && we_q && bus.mem_ready_i;
    // A suppressed field (write_en low) still occupies one cycle, then moves on.
    assign advance = (state_q == WRITE) && (!we_q || bus.mem_ready_i);

`ifdef CHANGED_ONLY_EN
    logic [FIELD_W-1:0] shadow_q [NUM_FIELDS];
    logic               shadow_valid_q;

    assign need_first = !shadow_valid_q || (in_f[0] != shadow_q[0]);
    assign need_next  = !shadow_valid_q || (snap_f[idx_nxt] != shadow_q[idx_nxt]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++) shadow_q[i] <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            if (accept) shadow_q[idx_q] <= data_q;
            if (done_d) shadow_valid_q <= 1'b1;
        end
    end
`else
    assign need_first = 1'b1;
    assign need_next  = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i || pending_q) begin
                    snap_d    = bus.fields_i;
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = WRITE;
                    addr_d    = BASE;
                    data_d    = in_f[0];
                    we_d      = need_first;
                end
            end
            WRITE: begin
                if (bus.start_i) pending_d = 1'b1;
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_nxt;
                        addr_d = BASE + ADDR_W'(idx_nxt);
                        data_d = snap_f[idx_nxt];
                        we_d   = need_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            done_q    <= done_d;
        end
    end

    assign bus.addr_o     = addr_q;
    assign bus.data_o     = data_q;
    assign bus.write_en_o = we_q;
    assign bus.busy_o     = (state_q == WRITE);
    assign bus.done_o     = done_q;
endmodule

// File: tb/tb_bcd_mem_sequencer.sv
// Self-checking bench for bcd_mem_sequencer: vector table, directed corner cases,
// and randomized traffic against a pass-level reference model.
module tb_bcd_mem_sequencer;
    localparam int N    = 6;
    localparam int FW   = 8;
    localparam int AW   = 4;
    localparam int BASE = 0;
    localparam logic [47:0] OLDF = 48'h99_12_31_23_59_59;
    localparam logic [47:0] NEWF = 48'h60_50_40_30_20_10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_mem_sequencer_if #(.NUM_FIELDS(N), .FIELD_W(FW), .ADDR_W(AW)) bus ();
    bcd_mem_sequencer #(.NUM_FIELDS(N), .FIELD_W(FW), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));

    bcd_mem_sequencer_if #(.NUM_FIELDS(3), .FIELD_W(8), .ADDR_W(4)) bus2 ();
    bcd_mem_sequencer #(.NUM_FIELDS(3), .FIELD_W(8), .ADDR_W(4), .BASE_ADDR(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [11:0] wlog[$];

    // Reference model: which field is on the bus (-1 = none), pending request, frozen pass data.
    int          m_pos, m_last;
    bit          m_pend, m_done, m_sv;
    logic [7:0]  m_snap[N];
    logic [7:0]  m_sh[N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic bit m_need(input int i);
`ifdef CHANGED_ONLY_EN
        return !m_sv || (m_snap[i] != m_sh[i]);
`else
        return (i >= 0);
`endif
    endfunction

    function automatic bit m_we();
        return (m_pos >= 0) && m_need(m_pos);
    endfunction

    function automatic logic [31:0] m_out();
        logic [3:0] a;
        logic [7:0] d;
        a = (m_last < 0) ? 4'd0 : 4'(BASE + m_last);
        d = (m_last < 0) ? 8'd0 : m_snap[m_last];
        return {17'd0, a, d, m_we(), (m_pos >= 0), m_done};
    endfunction

    function automatic logic [31:0] dut_out();
        return {17'd0, bus.addr_o, bus.data_o, bus.write_en_o, bus.busy_o, bus.done_o};
    endfunction

    task automatic model_reset();
        m_pos = -1; m_last = -1; m_pend = 0; m_done = 0; m_sv = 0;
        for (int i = 0; i < N; i++) begin m_snap[i] = '0; m_sh[i] = '0; end
    endtask

    task automatic model_step(input bit st, input bit rdy, input logic [47:0] flds);
        bit we_now;
        we_now = m_we();
        m_done = 0;
        if (m_pos < 0) begin
            if (st || m_pend) begin
                for (int i = 0; i < N; i++) m_snap[i] = flds[i*FW +: FW];
                m_pend = 0; m_pos = 0; m_last = 0;
            end
        end else begin
            if (st) m_pend = 1;
            if (we_now && rdy) m_sh[m_pos] = m_snap[m_pos];
            if (!we_now || rdy) begin
                if (m_pos == N - 1) begin
                    m_pos = -1; m_done = 1; m_sv = 1;
                end else begin
                    m_pos++; m_last = m_pos;
                end
            end
        end
    endtask

    task automatic cycle(input logic st, input logic rdy);
        bus.start_i     = st;
        bus.mem_ready_i = rdy;
        if (bus.write_en_o && rdy) wlog.push_back({bus.addr_o, bus.data_o});
        @(posedge clk);
        model_step(st, rdy, bus.fields_i);
        #1;
        check("model", dut_out(), m_out());
        if (bus.done_o) n_done++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus2.start_i = 1'b0;
        model_reset();
        #1;
        check("reset", dut_out(), '0);
        check("reset_dut2", {17'd0, bus2.addr_o, bus2.data_o, bus2.write_en_o, bus2.busy_o, bus2.done_o}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wlog.delete();
        n_done = 0;
    endtask

    typedef struct {
        bit         rst_before;
        logic       st;
        logic       rdy;
        logic [3:0] addr;
        logic [7:0] data;
        logic       we, busy, done;
    } vec_t;

    vec_t tbl[19];
    logic [7:0] oldb[N];
    logic [7:0] newb[N];

    initial begin
        int dc1, dc2, cyc;
        logic [11:0] e;
        logic [13:0] e2[4];
        logic [23:0] f6;

        tbl[0]  = '{1, 1, 1, 4'd0, 8'h59, 1, 1, 0};
        tbl[1]  = '{0, 0, 1, 4'd1, 8'h59, 1, 1, 0};
        tbl[2]  = '{0, 0, 1, 4'd2, 8'h23, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 4'd3, 8'h31, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 4'd4, 8'h12, 1, 1, 0};
        tbl[5]  = '{0, 0, 1, 4'd5, 8'h99, 1, 1, 0};
        tbl[6]  = '{0, 0, 1, 4'd5, 8'h99, 0, 0, 1};
        tbl[7]  = '{0, 0, 1, 4'd5, 8'h99, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 4'd0, 8'h59, 1, 1, 0};
        tbl[9]  = '{0, 0, 1, 4'd1, 8'h59, 1, 1, 0};
        tbl[10] = '{0, 0, 1, 4'd2, 8'h23, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 4'd2, 8'h23, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 4'd2, 8'h23, 1, 1, 0};
        tbl[13] = '{0, 0, 0, 4'd2, 8'h23, 1, 1, 0};
        tbl[14] = '{0, 0, 1, 4'd3, 8'h31, 1, 1, 0};
        tbl[15] = '{0, 0, 1, 4'd4, 8'h12, 1, 1, 0};
        tbl[16] = '{0, 0, 1, 4'd5, 8'h99, 1, 1, 0};
        tbl[17] = '{0, 0, 1, 4'd5, 8'h99, 0, 0, 1};
        tbl[18] = '{0, 0, 1, 4'd5, 8'h99, 0, 0, 0};
        for (int i = 0; i < N; i++) begin
            oldb[i] = OLDF[i*8 +: 8];
            newb[i] = NEWF[i*8 +: 8];
        end

        bus.fields_i = OLDF;
        bus.mem_ready_i = 1'b1;
        bus2.fields_i = 24'hC3_B2_A1;
        bus2.mem_ready_i = 1'b1;

        // Tests 1-2: plain pass, then a pass stalled 3 cycles on field 2.
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].rst_before) do_reset();
            cycle(tbl[i].st, tbl[i].rdy);
            check($sformatf("tbl[%0d]", i), dut_out(),
                  {17'd0, tbl[i].addr, tbl[i].data, tbl[i].we, tbl[i].busy, tbl[i].done});
        end

        // Test 3: start during write 3 with new fields; second pass must use them.
        do_reset();
        bus.fields_i = OLDF;
        cycle(1, 1); cycle(0, 1); cycle(0, 1);
        bus.fields_i = NEWF;
        cycle(1, 1);
        for (int i = 0; i < 20; i++) cycle(0, 1);
        check("t3_nwrites", wlog.size(), 12);
        check("t3_ndone", n_done, 2);
        for (int i = 0; i < 12 && i < wlog.size(); i++) begin
            e = (i < N) ? {4'(i), oldb[i]} : {4'(i - N), newb[i - N]};
            check($sformatf("t3_w%0d", i), wlog[i], e);
        end

        // Test 4: reset during write 4 with a pending start.
        do_reset();
        bus.fields_i = OLDF;
        cycle(1, 1); cycle(0, 1); cycle(0, 1); cycle(1, 1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_async", dut_out(), '0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 3; i++) cycle(0, 1);
        check("t4_no_done", n_done, 0);
        wlog.delete();
        cycle(1, 1);
        for (int i = 0; i < 7; i++) cycle(0, 1);
        check("t4_nwrites", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++)
            check($sformatf("t4_w%0d", i), wlog[i], {4'(i), oldb[i]});

        // Test 5: BASE_ADDR=8, NUM_FIELDS=3 instance.
        e2[0] = {4'd8,  8'hA1, 1'b1, 1'b1};
        e2[1] = {4'd9,  8'hB2, 1'b1, 1'b1};
        e2[2] = {4'd10, 8'hC3, 1'b1, 1'b1};
        e2[3] = {4'd10, 8'hC3, 1'b0, 1'b0};
        bus2.start_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1);
            bus2.start_i = 1'b0;
            check($sformatf("t5_c%0d", i), {18'd0, bus2.addr_o, bus2.data_o, bus2.write_en_o, bus2.busy_o}, e2[i]);
            check($sformatf("t5_done%0d", i), bus2.done_o, (i == 3));
        end

        // Test 6: two passes where only field 0 changes 0x00 -> 0x01.
        do_reset();
        f6 = '0;
        bus.fields_i = {OLDF[47:8], 8'h00};
        dc1 = -1; dc2 = -1;
        cycle(1, 1);
        for (cyc = 1; cyc < 10; cyc++) begin cycle(0, 1); if (bus.done_o && dc1 < 0) dc1 = cyc; end
        bus.fields_i = {OLDF[47:8], 8'h01};
        cycle(1, 1);
        for (cyc = 1; cyc < 10; cyc++) begin cycle(0, 1); if (bus.done_o && dc2 < 0) dc2 = cyc; end
        check("t6_done_pass1", dc1, N);
        check("t6_done_same", dc2, dc1);
`ifdef CHANGED_ONLY_EN
        check("t6_nwrites", wlog.size(), 7);
`else
        check("t6_nwrites", wlog.size(), 12);
`endif
        if (wlog.size() > 6) check("t6_sec", wlog[6], {4'd0, 8'h01});
        else check("t6_sec_missing", wlog.size(), 7);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                f6[7:0] = 8'($urandom_range(255));
                bus.fields_i[($urandom_range(N - 1)) * FW +: FW] = f6[7:0];
            end
            cycle($urandom_range(5) == 0, $urandom_range(3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
